aes_inv_sub_bytes_seq: RTL
==========================

AES_INV_SUB_BYTES_SEQ -- requirements
Module: aes_inv_sub_bytes_seq

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the bytes substituted per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the input block is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an input.
REQ-006 The block SHALL have port in_data, input, 128 bits: the input state; byte i = in_data[8i+7:8i].
REQ-007 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have port out_data, output, 128 bits: the substituted state, using the same byte mapping as in_data.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-011 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-012 In IDLE with in_valid=1, the block SHALL capture in_data into the 128-bit state register, clear the 4-bit byte counter, and enter BUSY on that edge.
REQ-013 In each BUSY cycle, the block SHALL replace LANES consecutive bytes, starting at byte index counter, with their AES inverse S-box values (FIPS-197 InvSbox), then advance counter by LANES.
REQ-014 BUSY SHALL last exactly N = 16/LANES cycles.
  - The update that makes counter reach 16 wraps counter to 0 and enters DONE on the same edge.
  - Worst-case latency is therefore N+1 edges from accept edge to out_valid, with no bubble cycles.
REQ-015 In DONE, out_data SHALL hold the state register stable until out_ready=1; on the out_ready=1 edge the block SHALL return to IDLE.
REQ-016 out_data SHALL be driven directly from the state register; its value outside DONE is don't-care for consumers but SHALL be deterministic.
REQ-017 The block SHALL NOT accept a new block in the same cycle a result is consumed; the next accept can occur no earlier than the following cycle.
REQ-018 in_data and in_valid SHALL be ignored in BUSY and DONE, and out_ready SHALL be ignored in IDLE and BUSY.
REQ-019 The inverse S-box SHALL be purely combinational per lane, with LANES parallel instances.

Reset
REQ-020 While rst=1, the block SHALL be in IDLE with counter=0, the state register=0, in_ready=1 and out_valid=0.
REQ-021 Reset asserted mid-BUSY or mid-DONE SHALL immediately abort the operation with no output handshake; after rst falls, the first accept SHALL start a fresh block.

Configuration
REQ-022 With macro AES_SUB_BIDIR_EN defined, the block SHALL add input port enc, 1 bit.
  - enc is sampled at accept and held for the block.
  - enc=1 selects the forward AES S-box in every lane; enc=0 selects the inverse S-box.
  - Timing and handshake are unchanged.
REQ-023 Without AES_SUB_BIDIR_EN, there SHALL be no enc port, and the block SHALL implement the inverse S-box only, with no forward S-box logic synthesized.

Verification
REQ-024 Reset test: rst pulse -> in_ready=1, out_valid=0, out_data=0 asynchronously, before any clk edge.
REQ-025 LANES=4, in_data=all bytes 0x63 -> out_valid on the 5th edge after accept, out_data=0; with out_ready held 1, back to IDLE on the next edge.
REQ-026 in_data=0x76abd7fe2b670130c56f6bf27b777c63 -> out_data=0x0f0e0d0c0b0a09080706050403020100; repeat for LANES=1 (17 edges) and LANES=16 (2 edges).
REQ-027 Bytes 0x52/0x09/0x16/0x00 at byte0..3 -> out bytes 0x48/0x40/0xff/0x52; out_ready held 0 for 10 cycles -> out_data stable, in_ready=0, new in_valid ignored.
REQ-028 rst asserted on the 2nd BUSY cycle -> IDLE immediately; a following accept of all-0x63 yields all-0x00 with the correct latency.
REQ-029 With AES_SUB_BIDIR_EN: enc=1, input all 0x00 -> output all 0x63; then enc=0 on that output -> all 0x00.

Source files
------------

// File: rtl/aes_inv_sub_bytes_seq.sv
// Multi-cycle AES InvSubBytes over a 128-bit state, LANES bytes per cycle.
// Define AES_SUB_BIDIR_EN to add an enc port selecting the forward S-box per block.
module aes_inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
`ifdef AES_SUB_BIDIR_EN
  input  logic         enc,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // LANES = 16 gives a zero step: the 4-bit counter wraps straight back to 0.
  localparam logic [3:0] CNT_STEP = 4'(LANES);
  localparam logic [3:0] CNT_LAST = 4'(16 - LANES);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

`ifdef AES_SUB_BIDIR_EN
  localparam logic [7:0] FWD_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
`endif

  state_t       state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [3:0]   cnt_q, cnt_d;
`ifdef AES_SUB_BIDIR_EN
  logic         enc_q, enc_d;
`endif

  logic [3:0] lane_idx [LANES];
  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = cnt_q + 4'(l);
    assign lane_in[l]  = data_q[{lane_idx[l], 3'b000} +: 8];
`ifdef AES_SUB_BIDIR_EN
    assign lane_out[l] = enc_q ? FWD_SBOX[lane_in[l]] : INV_SBOX[lane_in[l]];
`else
    assign lane_out[l] = INV_SBOX[lane_in[l]];
`endif
  end

  // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef AES_SUB_BIDIR_EN
    enc_d   = enc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
`ifdef AES_SUB_BIDIR_EN
          enc_d   = enc;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          data_d[{lane_idx[l], 3'b000} +: 8] = lane_out[l];
        end
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  // NOTE: the data register is reset too, keeping out_data deterministic from power-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef AES_SUB_BIDIR_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef AES_SUB_BIDIR_EN
      enc_q   <= enc_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;

endmodule
